// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access size codes,
// FSM state encoding and small lane/legality helpers.
package dmem_ctrl_pkg;

    // Load size/sign codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store size codes (funct3)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2,
        DMEM_ERR  = 2'd3
    } dmem_state_e;

    // True when the size code exists for the access direction and the byte
    // offset is naturally aligned for that size.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic code_ok;
        logic align_ok;
        if (is_store) begin
            code_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            code_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                      (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        case (f3[1:0])
            2'b10:   align_ok = (off == 2'b00);
            2'b01:   align_ok = ~off[0];
            default: align_ok = 1'b1;
        endcase
        return code_ok && align_ok;
    endfunction

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] lane_be(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the enabled lanes carry it.
    function automatic logic [31:0] lane_wdata(input logic [2:0]  f3,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the core's load/store stage, the controller and the
// word-wide backing memory.
//
// Handshakes: the core raises memRead/memWrite with funct3/addr/wdata and
// must hold them stable while stall=1; the access is complete on the first
// cycle with stall=0. Toward memory, mem_req plus the mem_* command stay
// stable until the single-cycle mem_ack arrives (mem_rdata valid with it).
interface dmem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              memRead;
    logic              memWrite;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              stall;
    logic              mem_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // Controller side
    modport slave (
        input  memRead, memWrite, funct3, addr, wdata, mem_ack, mem_rdata,
        output rdata, stall, mem_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    // Core + memory environment side
    modport master (
        output memRead, memWrite, funct3, addr, wdata, mem_ack, mem_rdata,
        input  rdata, stall, mem_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/dmem_ctrl_load_extend.sv
// Extracts a byte/half/word from a memory word at a byte offset and sign- or
// zero-extends it according to funct3. Purely combinational.
module dmem_ctrl_load_extend
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [31:0] w_shifted;

    // Align the addressed lane down to bit 0, then extend by size and sign
    always_comb begin
        w_shifted = i_word >> {i_offset, 3'b000};
        case (i_funct3[1:0])
            2'b00:   o_data = i_funct3[2] ? {24'b0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   o_data = i_funct3[2] ? {16'b0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store per request, word-wide memory
// req/ack handshake, extended load data, pipeline stall and error pulse.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus,
    output logic [1:0]  o_dbg_state
);
    // Counter only has to reach TIMEOUT-1
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    dmem_state_e       r_state;
    dmem_state_e       w_next;
    logic              w_req;
    logic              w_is_store;
    logic              w_legal;
    logic              w_stall;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;
    logic [31:0]       w_ext;

    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic [1:0]        r_offset;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rdata;

    // A simultaneous read and write request is treated as a store
    assign w_req      = bus.memRead | bus.memWrite;
    assign w_is_store = bus.memWrite;
    assign w_legal    = access_legal(w_is_store, bus.funct3, bus.addr[1:0]);

    dmem_ctrl_load_extend u_load_extend (
        .i_word   (bus.mem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, stall and datapath strobes
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    if (w_legal) begin
                        w_accept = 1'b1;
                        w_next   = DMEM_BUSY;
                    end else begin
                        w_next   = DMEM_ERR;
                    end
                end
            end
            DMEM_BUSY: begin
                w_stall = 1'b1;
                // An ack arriving on the final allowed cycle still completes
                if (bus.mem_ack) begin
                    w_done = 1'b1;
                    w_next = DMEM_DONE;
                end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
                    w_timeout = 1'b1;
                    w_next    = DMEM_ERR;
                end
            end
            // DONE and ERR always return to IDLE so the still-present request
            // of the completing instruction cannot start a second access
            DMEM_DONE: w_next = DMEM_IDLE;
            DMEM_ERR:  w_next = DMEM_IDLE;
            default:   w_next = DMEM_IDLE;
        endcase
    end

    // Memory command: captured on accept, held for the whole BUSY phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_funct3    <= '0;
            r_offset    <= '0;
        end else if (w_accept) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= bus.addr[ADDR_W+1:2];
            r_mem_be    <= lane_be(bus.funct3, bus.addr[1:0]);
            r_mem_wdata <= lane_wdata(bus.funct3, bus.wdata);
            r_funct3    <= bus.funct3;
            r_offset    <= bus.addr[1:0];
        end else if (w_done || w_timeout) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Load result: extended word on completion, zero for stores and errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_done) begin
            r_rdata <= r_mem_we ? 32'h0 : w_ext;
        end else if (w_next == DMEM_ERR) begin
            r_rdata <= '0;
        end
    end

    // Wait-cycle counter, restarted whenever BUSY is not waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == DMEM_BUSY) && !bus.mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.stall     = w_stall;
    assign bus.mem_err   = (r_state == DMEM_ERR);
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the load/store control signals produced by instruction decode (memRead, memWrite) in the core.
- Accepts one byte/half/word access per instruction, drives a word-wide backing memory port with a req/ack handshake, and returns sign/zero-extended load data.
- Holds the pipeline via stall until the access completes.
- Flags misaligned, illegal-width and timed-out accesses via a one-cycle error.

Parameters:
- ADDR_W, 10, word-address width of backing memory (mem_addr = addr[ADDR_W+1:2]).
- TIMEOUT, 255, max BUSY cycles waiting for mem_ack before error; 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- memRead  in  1  load request from decode.
- memWrite  in  1  store request from decode.
- funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load data; valid while state is DONE.
- stall  out  1  hold pipeline (combinational).
- mem_err  out  1  one-cycle access error pulse.
- mem_req  out  1  backing-memory request (registered).
- mem_we  out  1  write enable (registered).
- mem_addr  out  ADDR_W  word address (registered).
- mem_be  out  4  byte lane enables (registered).
- mem_wdata  out  32  lane-replicated store data (registered).
- mem_ack  in  1  memory completion, valid for one cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

Behaviour:
- Reset: state=IDLE. All registered outputs and rdata are 0, mem_err=0, counter=0. Assertion mid-access drops mem_req immediately (async).
- Request: req = memRead | memWrite. When both are set, the write wins and the read is ignored.
- Legality (checked in IDLE):
  - Word requires addr[1:0]==0.
  - Half requires addr[0]==0.
  - Store funct3 must be 000, 001 or 010.
  - Load funct3 must be 000, 001, 010, 100 or 101.
- States:
  - IDLE:
    - req and legal: latch mem_addr, mem_we, mem_be, mem_wdata, funct3 and addr[1:0]; stall=1; next state BUSY.
    - req and illegal: next state ERR; stall=1; no memory access.
    - Otherwise stall=0.
  - BUSY:
    - mem_req=1; all mem_* outputs held stable; stall=1.
    - mem_ack: capture extended rdata; mem_req=0; next state DONE.
    - Else counter++. If TIMEOUT!=0 and counter reaches TIMEOUT-1: mem_req=0, next state ERR.
    - mem_ack in the same cycle as the timeout: ack wins.
  - DONE: stall=0; rdata valid; next state IDLE unconditionally. The request still visible on the inputs this cycle must not retrigger.
  - ERR: stall=0, mem_err=1, rdata=0; next state IDLE unconditionally.
- Latency: a legal access with ack in the first BUSY cycle stalls 2 cycles. rdata is presented in cycle 3 (DONE).
- Store lanes:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=addr[1]?4'b1100:4'b0011.
  - SW: mem_be=4'b1111.
- Load extraction: shift mem_rdata right by 8*offset, then sign- or zero-extend the byte/half per funct3[2]. A store completion leaves rdata=0.
- mem_ack while not in BUSY: ignored.

Decomposition:
- Shared defines file holds:
  - FUNCT3 size codes (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - State encodings DMEM_IDLE/BUSY/DONE/ERR (2 bits).
- One natural sub-module: load_extend (combinational: word, offset, funct3 -> 32-bit extended data). It can be reused by an instruction-fetch path.

Test Plan:
- LW addr=0x10, mem_rdata=0xDEADBEEF, ack in the first BUSY cycle -> mem_addr=4, stall high 2 cycles, rdata=0xDEADBEEF in DONE, mem_err=0.
- LB addr=0x13 and LBU addr=0x13, mem_rdata=0x80FF_0000 -> rdata=0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH addr=0x22, wdata=0x1234ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=8, rdata=0.
- LW addr=0x5 -> no mem_req, stall high 1 cycle, mem_err pulses one cycle, rdata=0.
- TIMEOUT=4, ack never returned -> mem_req high exactly 4 cycles, then ERR pulse, then IDLE. Ack landing on the 4th cycle -> normal DONE, no error.
- rst_n low during BUSY -> mem_req falls without waiting for clk. After release, state=IDLE and a new SW completes normally.
